// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants (opcodes, extender modes, reset PC) and the extender-mode predecode
// Used by the fetch stage, the immediate extender and the controller.
package cpu_pkg;
    localparam logic [5:0]  OP_ANDI = 6'h0C;
    localparam logic [5:0]  OP_ORI  = 6'h0D;
    localparam logic [5:0]  OP_XORI = 6'h0E;
    localparam logic [5:0]  OP_LUI  = 6'h0F;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2,
        EXT_RSVD = 2'd3
    } ext_sel_t;
    // Logical immediates zero-extend, lui shifts into the upper half, everything else sign-extends.
    function automatic ext_sel_t ext_mode(input logic [5:0] op);
        return (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? EXT_ZERO :
               (op == OP_LUI) ? EXT_LUI : EXT_SIGN;
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush (bubble), stall (hold) and valid tracking
// Ports: clk, reset (sync, active-high); stall holds, flush loads a bubble (flush wins);
//        instr_in/pc_in/ext_in are the fetched word, its PC and its predecoded extender mode;
//        instr/pc/ext_sel/valid are the registered D-stage copies.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [1:0]  ext_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [1:0]  ext_sel,
    output logic        valid
);
    // A flushed slot keeps the PC of the squashed fetch so the bubble stays traceable.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr   <= NOP_INSTR;
            pc      <= RESET_PC;
            ext_sel <= EXT_SIGN;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= NOP_INSTR;
            pc      <= pc_in;
            ext_sel <= EXT_SIGN;
            valid   <= 1'b0;
        end else if (!stall) begin
            instr   <= instr_in;
            pc      <= pc_in;
            ext_sel <= ext_in;
            valid   <= 1'b1;
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage (PC, next-PC select, extender predecode, IF/ID register)
// Ports: clk, reset (sync, active-high); im_addr/im_rdata combinational instruction memory;
//        stall_D, flush_D, redirect_en, redirect_pc from the D stage / hazard unit;
//        instr_D, pc_D, pc8_D, imm16_D, ext_sel_D, valid_D towards the D stage.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic [15:0] imm16_D,
    output logic [1:0]  ext_sel_D,
    output logic        valid_D
);
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [1:0]  ext_f;
    // A redirect during a stall is dropped; the D stage re-asserts it once the stall clears.
    // The delay slot is never squashed here, so the redirect only steers the PC.
    always_comb pc_next = stall_D ? pc :
                          redirect_en ? (redirect_pc & ~32'd3) : pc + 32'd4;
    always_ff @(posedge clk) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_next;
    end
    assign im_addr = pc;
    assign ext_f   = ext_mode(im_rdata[31:26]);
    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall_D),
        .flush   (flush_D),
        .instr_in(im_rdata),
        .pc_in   (pc),
        .ext_in  (ext_f),
        .instr   (instr_D),
        .pc      (pc_D),
        .ext_sel (ext_sel_D),
        .valid   (valid_D)
    );
    assign pc8_D   = pc_D + 32'd8;
    assign imm16_D = instr_D[15:0];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + randomized check of if_stage against a cycle-level behavioural model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset, stall_D, flush_D, redirect_en;
    logic [31:0] redirect_pc, im_addr, im_rdata, instr_D, pc_D, pc8_D;
    logic [15:0] imm16_D;
    logic [1:0]  ext_sel_D;
    logic        valid_D;
    logic        ovr;
    logic [31:0] ovr_word;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc, m_instr, m_pcd;
    logic [1:0]  m_ext;
    logic        m_valid;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .stall_D    (stall_D),
        .flush_D    (flush_D),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc8_D      (pc8_D),
        .imm16_D    (imm16_D),
        .ext_sel_D  (ext_sel_D),
        .valid_D    (valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    always_comb im_rdata = ovr ? ovr_word : mem_word(im_addr);

    function automatic logic [1:0] ext_of(input logic [31:0] w);
        int op;
        op = int'(w >> 26);
        if (op >= 12 && op <= 14) return 2'd0;
        if (op == 15) return 2'd2;
        return 2'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("im_addr", im_addr, m_pc);
        chk("instr_D", instr_D, m_instr);
        chk("pc_D", pc_D, m_pcd);
        chk("pc8_D", pc8_D, m_pcd + 32'd8);
        chk("imm16_D", {16'h0, imm16_D}, {16'h0, m_instr[15:0]});
        chk("ext_sel_D", {30'h0, ext_sel_D}, {30'h0, m_ext});
        chk("valid_D", {31'h0, valid_D}, {31'h0, m_valid});
    endtask

    // One clock: apply inputs, advance the model by the fetch-stage rules, compare #1 after the edge.
    task automatic tick(input logic r, input logic s, input logic f, input logic re, input logic [31:0] rp);
        logic [31:0] fetched;
        reset = r; stall_D = s; flush_D = f; redirect_en = re; redirect_pc = rp;
        @(posedge clk);
        fetched = ovr ? ovr_word : mem_word(m_pc);
        if (r) begin
            m_pc = 32'h3000; m_instr = 32'h0; m_pcd = 32'h3000; m_ext = 2'd1; m_valid = 1'b0;
        end else begin
            if (f) begin
                m_instr = 32'h0; m_pcd = m_pc; m_ext = 2'd1; m_valid = 1'b0;
            end else if (!s) begin
                m_instr = fetched; m_pcd = m_pc; m_ext = ext_of(fetched); m_valid = 1'b1;
            end
            if (!s) m_pc = re ? {rp[31:2], 2'b00} : m_pc + 32'd4;
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] pc0, i0, w;
        logic [31:0] ops [4];
        ops[0] = 32'h0C; ops[1] = 32'h0D; ops[2] = 32'h0E; ops[3] = 32'h0F;
        ovr = 1'b0; ovr_word = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_ext = 2'd0; m_valid = 1'b0;
        reset = 1'b1; stall_D = 1'b0; flush_D = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst_im_addr", im_addr, 32'h3000);
        chk("rst_valid", {31'h0, valid_D}, 32'h0);
        chk("rst_ext", {30'h0, ext_sel_D}, 32'h1);
        chk("rst_pc_D", pc_D, 32'h3000);
        tick(0, 0, 0, 0, 0);
        chk("run_im_addr1", im_addr, 32'h3004);
        chk("run_pc_D", pc_D, 32'h3000);
        chk("run_valid", {31'h0, valid_D}, 32'h1);
        tick(0, 0, 0, 0, 0);
        chk("run_im_addr2", im_addr, 32'h3008);
        ovr = 1'b1;
        ovr_word = 32'h3421_00FF; tick(0, 0, 0, 0, 0);
        chk("ori_ext", {30'h0, ext_sel_D}, 32'h0);
        chk("ori_imm", {16'h0, imm16_D}, 32'h00FF);
        ovr_word = 32'h3C01_1234; tick(0, 0, 0, 0, 0);
        chk("lui_ext", {30'h0, ext_sel_D}, 32'h2);
        chk("lui_imm", {16'h0, imm16_D}, 32'h1234);
        ovr_word = 32'h2021_FFFF; tick(0, 0, 0, 0, 0);
        chk("addi_ext", {30'h0, ext_sel_D}, 32'h1);
        chk("addi_imm", {16'h0, imm16_D}, 32'hFFFF);
        ovr = 1'b0;
        pc0 = im_addr; i0 = instr_D;
        tick(0, 1, 0, 1, 32'h4000);
        tick(0, 1, 0, 1, 32'h4000);
        chk("stall_pc", im_addr, pc0);
        chk("stall_instr", instr_D, i0);
        tick(0, 0, 0, 0, 0);
        chk("stall_no_redirect", im_addr, pc0 + 32'd4);
        pc0 = im_addr;
        tick(0, 0, 0, 1, 32'h4002);
        chk("delay_slot_instr", instr_D, mem_word(pc0));
        chk("redirect_addr", im_addr, 32'h4000);
        tick(0, 0, 0, 0, 0);
        chk("redirect_next", im_addr, 32'h4004);
        tick(0, 1, 1, 0, 0);
        chk("flush_valid", {31'h0, valid_D}, 32'h0);
        chk("flush_instr", instr_D, 32'h0);
        chk("flush_pc_held", im_addr, 32'h4004);
        tick(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_pc", im_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0);
        chk("wrap_im_addr", im_addr, 32'h0);
        chk("wrap_pc8", pc8_D, 32'h4);
        tick(0, 0, 0, 1, 32'h3020);
        tick(1, 1, 0, 1, 32'h5000);
        chk("rst_stall_addr", im_addr, 32'h3000);
        chk("rst_stall_valid", {31'h0, valid_D}, 32'h0);
        tick(0, 0, 0, 0, 0);
        chk("rst_release_pc_D", pc_D, 32'h3000);
        for (int i = 0; i < 400; i++) begin
            ovr = ($urandom_range(0, 3) == 0);
            w = $urandom;
            ovr_word = {ops[$urandom_range(0, 3)][5:0], w[25:0]};
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w = 32'hFFFF_FFF0 | (w & 32'hF);
            tick($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, w);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
